// File: rtl/axi_lite_mmr_master_pkg.sv
// Shared types for the AXI-Lite MMR initiator: FSM state encoding and AXI response codes.
package axi_lite_mmr_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_channels.sv
// AXI-Lite channel interfaces (AW, W, B, AR, R), each with master and slave modports.
interface axi_lite_write_address_channel #(parameter int ADDR_WIDTH = 32);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  modport master (output awaddr, awprot, awvalid, input awready);
  modport slave  (input awaddr, awprot, awvalid, output awready);
endinterface

interface axi_lite_write_channel #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  modport master (output wdata, wstrb, wvalid, input wready);
  modport slave  (input wdata, wstrb, wvalid, output wready);
endinterface

interface axi_lite_write_response_channel;
  logic [1:0] bresp;
  logic       bvalid;
  logic       bready;
  modport master (input bresp, bvalid, output bready);
  modport slave  (output bresp, bvalid, input bready);
endinterface

interface axi_lite_read_address_channel #(parameter int ADDR_WIDTH = 32);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  modport master (output araddr, arprot, arvalid, input arready);
  modport slave  (input araddr, arprot, arvalid, output arready);
endinterface

interface axi_lite_read_channel #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  modport master (input rdata, rresp, rvalid, output rready);
  modport slave  (output rdata, rresp, rvalid, input rready);
endinterface

// File: rtl/axi_lite_mmr_master.sv
// Single-outstanding request/response port to AXI-Lite initiator.
// Optional statistics counters are built when AXI_LITE_MMR_MASTER_STATS_EN is defined.
module axi_lite_mmr_master
  import axi_lite_mmr_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_code,
  axi_lite_write_address_channel.master  axi_aw,
  axi_lite_write_channel.master          axi_w,
  axi_lite_write_response_channel.master axi_b,
  axi_lite_read_address_channel.master   axi_ar,
  axi_lite_read_channel.master           axi_r,
  output logic [STAT_WIDTH-1:0] stat_wr_count,
  output logic [STAT_WIDTH-1:0] stat_rd_count,
  output logic [STAT_WIDTH-1:0] stat_err_count
);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH-1:2]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [3:0]              r_wstrb;
  logic                    r_aw_done;
  logic                    r_w_done;
  logic                    r_ar_done;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_code;

  logic w_req_ready;
  logic w_resp_valid;
  logic w_awvalid;
  logic w_wvalid;
  logic w_bready;
  logic w_arvalid;
  logic w_rready;
  logic w_req_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;
  // Byte-lane bits of the request address are dropped: accesses are word aligned.
  logic w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^req_addr[1:0];

  assign w_req_hs = req_valid & w_req_ready;
  assign w_aw_hs  = w_awvalid & axi_aw.awready;
  assign w_w_hs   = w_wvalid & axi_w.wready;
  assign w_b_hs   = w_bready & axi_b.bvalid;
  assign w_ar_hs  = w_arvalid & axi_ar.arready;
  assign w_r_hs   = w_rready & axi_r.rvalid;

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_req_hs) w_next_state = req_write ? WRITE : READ;
      WRITE:   if (w_b_hs)   w_next_state = DONE;
      READ:    if (w_r_hs)   w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_awvalid    = 1'b0;
    w_wvalid     = 1'b0;
    w_bready     = 1'b0;
    w_arvalid    = 1'b0;
    w_rready     = 1'b0;
    case (r_state)
      IDLE:  w_req_ready = reset_n;
      WRITE: begin
        w_awvalid = ~r_aw_done;
        w_wvalid  = ~r_w_done;
        w_bready  = 1'b1;
      end
      READ: begin
        w_arvalid = ~r_ar_done;
        w_rready  = 1'b1;
      end
      DONE:    w_resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Per-channel completion flags let AW and W handshake independently.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_ar_done <= 1'b0;
    end else if (w_req_hs) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_ar_done <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (w_ar_hs) r_ar_done <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_req_hs) begin
      r_addr  <= req_addr[ADDR_WIDTH-1:2];
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rdata <= '0;
      r_code  <= AXI_RESP_OKAY;
    end else if (w_b_hs) begin
      r_rdata <= '0;
      r_code  <= axi_b.bresp;
    end else if (w_r_hs) begin
      r_rdata <= axi_r.rdata;
      r_code  <= axi_r.rresp;
    end
  end

  assign req_ready      = w_req_ready;
  assign resp_valid     = w_resp_valid;
  assign resp_rdata     = r_rdata;
  assign resp_code      = r_code;

  assign axi_aw.awaddr  = {r_addr, 2'b00};
  assign axi_aw.awprot  = 3'b000;
  assign axi_aw.awvalid = w_awvalid;
  assign axi_w.wdata    = r_wdata;
  assign axi_w.wstrb    = r_wstrb;
  assign axi_w.wvalid   = w_wvalid;
  assign axi_b.bready   = w_bready;
  assign axi_ar.araddr  = {r_addr, 2'b00};
  assign axi_ar.arprot  = 3'b000;
  assign axi_ar.arvalid = w_arvalid;
  assign axi_r.rready   = w_rready;

`ifdef AXI_LITE_MMR_MASTER_STATS_EN
  logic                  r_write;
  logic [STAT_WIDTH-1:0] r_wr_count;
  logic [STAT_WIDTH-1:0] r_rd_count;
  logic [STAT_WIDTH-1:0] r_err_count;

  always_ff @(posedge clock) begin
    if (w_req_hs) r_write <= req_write;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_count  <= '0;
      r_rd_count  <= '0;
      r_err_count <= '0;
    end else if (r_state == DONE) begin
      if (r_write) r_wr_count <= r_wr_count + 1'b1;
      else         r_rd_count <= r_rd_count + 1'b1;
      if (r_code != AXI_RESP_OKAY) r_err_count <= r_err_count + 1'b1;
    end
  end

  assign stat_wr_count  = r_wr_count;
  assign stat_rd_count  = r_rd_count;
  assign stat_err_count = r_err_count;
`else
  assign stat_wr_count  = '0;
  assign stat_rd_count  = '0;
  assign stat_err_count = '0;
`endif

endmodule
